tick_rate_controller: RTL and testbench

//   Game-pace sequencer for the pong datapath. Owns one programmable tick divider and emits a
//   1-cycle update strobe (game_tick) every period+1 clocks. Sequences IDLE -> SERVE -> RUN,

---
 rtl/tick_rate_controller.sv | 199 +++++++++++++++++++
 tb/tb_tick_rate_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_rate_controller.sv
// -----------------------------------------------------------------------------
// tick_rate_controller
//
// Game-pace sequencer for the pong datapath. One programmable divider runs
// while the game is active. Each time the divider wraps, the block emits a
// one-clock strobe:
//   - serve_tick while serving, which drives the serve countdown display;
//   - game_tick while running, which paces the ball/paddle update logic.
// The block sequences IDLE -> SERVE -> RUN. It shortens the divider period
// when a paddle hit is reported, and it freezes while pause is held.
//
// Ports
//   clk         in   1        system clock
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        pulse: leave IDLE and begin the serve
//   restart     in   1        pulse: reload START_PERIOD, level 0, re-enter SERVE
//   speed_up    in   1        pulse: request period -= STEP (paddle hit)
//   pause       in   1        level: freeze the divider and the FSM while high
//   game_tick   out  1        one-clock strobe on each divider wrap in RUN
//   serve_tick  out  1        one-clock strobe on each divider wrap in SERVE
//   period      out  WIDTH    current divider period (wrap every period+1 clks)
//   level       out  LEVEL_W  accepted speed-ups since last restart, saturating
//   running     out  1        high while in RUN
//
// Parameters
//   WIDTH         divider counter/period width
//   START_PERIOD  period loaded at reset and on restart
//   MIN_PERIOD    floor of the speed ramp (must not exceed START_PERIOD)
//   STEP          period decrement per accepted speed-up
//   SERVE_TICKS   divider wraps spent in SERVE before RUN (at least 1)
//   LEVEL_W       width of the speed level counter
// -----------------------------------------------------------------------------
module tick_rate_controller #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned START_PERIOD = 833333,
   parameter int unsigned MIN_PERIOD   = 208333,
   parameter int unsigned STEP         = 62500,
   parameter int unsigned SERVE_TICKS  = 60,
   parameter int unsigned LEVEL_W      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               restart,
   input  logic               speed_up,
   input  logic               pause,
   output logic               game_tick,
   output logic               serve_tick,
   output logic [WIDTH-1:0]   period,
   output logic [LEVEL_W-1:0] level,
   output logic               running
);

   // serve_cnt only has to hold 0 .. SERVE_TICKS-1.
   localparam int unsigned SC_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

   localparam logic [WIDTH-1:0]   START_P    = WIDTH'(START_PERIOD);
   localparam logic [WIDTH-1:0]   MIN_P      = WIDTH'(MIN_PERIOD);
   localparam logic [WIDTH-1:0]   STEP_P     = WIDTH'(STEP);
   localparam logic [SC_W-1:0]    SERVE_LAST = SC_W'(SERVE_TICKS - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_RUN   = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t           state;
   state_t           saved_state;   // SERVE or RUN, the state to return to after PAUSE
   logic [WIDTH-1:0] counter;
   logic [SC_W-1:0]  serve_cnt;
   logic             pend;          // speed-up requested, waiting for the next RUN wrap

   // Derived, combinational view of the current cycle.
   state_t           resume_state;  // the state this cycle acts as when pause is low
   logic             count_en;
   logic             wrap;
   logic [WIDTH-1:0] ramp_period;
   logic             ramp_takes;

   // NOTE: every signal written here gets a value on every path through the
   // block. A path that leaves a signal unassigned would infer a latch.
   always_comb begin
      resume_state = (state == ST_PAUSE) ? saved_state : state;

      // The divider runs in every active state whenever pause is low. This
      // includes the cycle that releases a pause, so a pause of N clocks
      // delays the pending strobe by exactly N clocks.
      count_en = (state != ST_IDLE) && !pause;
      wrap     = count_en && (counter == period);

      // Because period never drops below MIN_P, period - MIN_P cannot
      // underflow. Comparing that headroom against STEP_P decides between a
      // full step and a clamp to the floor, so the decrement itself cannot
      // wrap around.
      if ((period - MIN_P) >= STEP_P) begin
         ramp_period = period - STEP_P;
      end else begin
         ramp_period = MIN_P;
      end
      ramp_takes = (ramp_period != period);
   end

   // NOTE: sequential state uses non-blocking assignments only. Every register
   // then samples the values from before the edge, and a later assignment in
   // the same block overrides an earlier one. The pend clear at a RUN wrap
   // relies on that override.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         saved_state <= ST_IDLE;
         counter     <= '0;
         serve_cnt   <= '0;
         pend        <= 1'b0;
         period      <= START_P;
         level       <= '0;
         game_tick   <= 1'b0;
         serve_tick  <= 1'b0;
         running     <= 1'b0;
      end else if (restart && (state != ST_IDLE)) begin
         // A point was scored. Start again from a fresh serve at the base
         // speed. Any wrap in this cycle is dropped.
         state      <= ST_SERVE;
         counter    <= '0;
         serve_cnt  <= '0;
         pend       <= 1'b0;
         period     <= START_P;
         level      <= '0;
         game_tick  <= 1'b0;
         serve_tick <= 1'b0;
         running    <= 1'b0;
      end else begin
         // The strobes are one clock wide by default.
         game_tick  <= 1'b0;
         serve_tick <= 1'b0;

         case (state)
            ST_IDLE: begin
               running <= 1'b0;
               if (start) begin
                  state     <= ST_SERVE;
                  counter   <= '0;
                  serve_cnt <= '0;
               end
            end

            default: begin   // ST_SERVE, ST_RUN, ST_PAUSE
               // A hit is remembered even while paused. Several hits before
               // the next wrap collapse into a single request.
               if (speed_up) begin
                  pend <= 1'b1;
               end

               if (pause) begin
                  if (state != ST_PAUSE) begin
                     saved_state <= state;
                  end
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end else begin
                  state   <= resume_state;
                  running <= (resume_state == ST_RUN);

                  if (wrap) begin
                     counter <= '0;
                     if (resume_state == ST_SERVE) begin
                        serve_tick <= 1'b1;
                        if (serve_cnt == SERVE_LAST) begin
                           state   <= ST_RUN;
                           running <= 1'b1;
                        end else begin
                           serve_cnt <= serve_cnt + SC_W'(1);
                        end
                     end else begin
                        game_tick <= 1'b1;
                        // A hit that arrives with the wrap counts at this
                        // wrap. The new period takes effect for the next
                        // interval, because the counter has just restarted
                        // from zero.
                        if (pend || speed_up) begin
                           period <= ramp_period;
                           pend   <= 1'b0;
                           if (ramp_takes && (level != LEVEL_MAX)) begin
                              level <= level + LEVEL_W'(1);
                           end
                        end
                     end
                  end else begin
                     counter <= counter + WIDTH'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tick_rate_controller.sv
module tb_tick_rate_controller;

   localparam int WIDTH        = 8;
   localparam int START_PERIOD = 9;
   localparam int MIN_PERIOD   = 3;
   localparam int STEP         = 4;
   localparam int SERVE_TICKS  = 2;
   localparam int LEVEL_W      = 2;
   localparam int LEVEL_MAX    = (1 << LEVEL_W) - 1;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               restart = 1'b0;
   logic               speed_up = 1'b0;
   logic               pause = 1'b0;
   logic               game_tick;
   logic               serve_tick;
   logic [WIDTH-1:0]   period;
   logic [LEVEL_W-1:0] level;
   logic               running;

   int n_cmp = 0;
   int n_bad = 0;

   tick_rate_controller #(
      .WIDTH        (WIDTH),
      .START_PERIOD (START_PERIOD),
      .MIN_PERIOD   (MIN_PERIOD),
      .STEP         (STEP),
      .SERVE_TICKS  (SERVE_TICKS),
      .LEVEL_W      (LEVEL_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .restart    (restart),
      .speed_up   (speed_up),
      .pause      (pause),
      .game_tick  (game_tick),
      .serve_tick (serve_tick),
      .period     (period),
      .level      (level),
      .running    (running)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Advance one clock. Outputs are then sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count clocks until the selected strobe is seen. The result is -1 if the
   // strobe does not arrive within the limit.
   task automatic wait_strobe(input bit want_game, input int limit, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < limit) begin
         step();
         n++;
         seen = want_game ? game_tick : serve_tick;
      end
      if (!seen) n = -1;
   endtask

   // ---------------- behavioural reference model ----------------
   // The model keeps a countdown of clocks left in the current interval and a
   // count of serves still to go. The expected outputs are what should be
   // visible after the edge that consumes the given inputs.
   localparam int P_IDLE = 0, P_SERVE = 1, P_RUN = 2;
   int m_phase, m_left, m_serves_left, m_period, m_level;
   bit m_pend, m_paused, m_game, m_serve;

   task automatic model_reset();
      m_phase = P_IDLE; m_left = 0; m_serves_left = 0;
      m_period = START_PERIOD; m_level = 0;
      m_pend = 0; m_paused = 0; m_game = 0; m_serve = 0;
   endtask

   task automatic model_step(input bit st, input bit rs, input bit su, input bit pa);
      int new_p;
      m_game = 0;
      m_serve = 0;
      if (m_phase == P_IDLE) begin
         if (st) begin
            m_phase = P_SERVE; m_left = m_period + 1;
            m_serves_left = SERVE_TICKS; m_paused = 0;
         end
      end else if (rs) begin
         m_phase = P_SERVE; m_period = START_PERIOD; m_level = 0; m_pend = 0;
         m_left = START_PERIOD + 1; m_serves_left = SERVE_TICKS; m_paused = 0;
      end else begin
         if (su) m_pend = 1;
         m_paused = pa;
         if (!pa) begin
            m_left--;
            if (m_left == 0) begin
               if (m_phase == P_SERVE) begin
                  m_serve = 1;
                  m_serves_left--;
                  if (m_serves_left == 0) m_phase = P_RUN;
               end else begin
                  m_game = 1;
                  if (m_pend) begin
                     new_p = m_period - STEP;
                     if (new_p < MIN_PERIOD) new_p = MIN_PERIOD;
                     if (new_p < m_period && m_level < LEVEL_MAX) m_level++;
                     m_period = new_p;
                     m_pend = 0;
                  end
               end
               m_left = m_period + 1;
            end
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic st, rs, su, pa;
      int   reps;
      logic game, serve, run;
      int   per, lvl;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   initial begin
      int n;
      int strobes;
      int seen_serve;

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 9, 0}; // restart ignored in IDLE
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 9, 0}; // speed_up/pause ignored in IDLE
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 9, 0}; // stays IDLE
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 9, 0}; // start -> SERVE
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b0, 9, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 9, 0}; // first serve tick, 10 clks after start
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b0, 9, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 9, 0}; // second serve tick, enter RUN
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b1, 9, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 9, 0}; // first game tick
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 9, 0}; // start ignored in RUN
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b1, 9, 0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 9, 0}; // game tick 10 clks later

      // Reset values
      repeat (2) step();
      check("rst_game_tick", 32'(game_tick), 32'd0);
      check("rst_serve_tick", 32'(serve_tick), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_period", 32'(period), 32'(START_PERIOD));
      check("rst_level", 32'(level), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            start = vecs[i].st; restart = vecs[i].rs;
            speed_up = vecs[i].su; pause = vecs[i].pa;
            step();
            check($sformatf("vec%0d.%0d_game", i, r), 32'(game_tick), 32'(vecs[i].game));
            check($sformatf("vec%0d.%0d_serve", i, r), 32'(serve_tick), 32'(vecs[i].serve));
            check($sformatf("vec%0d.%0d_run", i, r), 32'(running), 32'(vecs[i].run));
            check($sformatf("vec%0d.%0d_period", i, r), 32'(period), 32'(vecs[i].per));
            check($sformatf("vec%0d.%0d_level", i, r), 32'(level), 32'(vecs[i].lvl));
         end
      end
      start = 0; restart = 0; speed_up = 0; pause = 0;

      // Three hits in one RUN interval collapse into one: the current
      // interval stays 10 clks, the next one is 6 clks, and level is 1.
      speed_up = 1; step(); speed_up = 0; step();
      speed_up = 1; step(); speed_up = 0; step();
      speed_up = 1; step(); speed_up = 0;
      wait_strobe(1'b1, 30, n);
      check("ramp_cur_interval_rest", 32'(n), 32'd5);
      check("ramp_period_5", 32'(period), 32'd5);
      check("ramp_level_1", 32'(level), 32'd1);
      wait_strobe(1'b1, 30, n);
      check("ramp_next_interval", 32'(n), 32'd6);

      // Clamp at MIN_PERIOD, then a hit with the period already at the floor.
      speed_up = 1; step(); speed_up = 0;
      wait_strobe(1'b1, 30, n);
      check("clamp_interval_rest", 32'(n), 32'd5);
      check("clamp_period_3", 32'(period), 32'd3);
      check("clamp_level_2", 32'(level), 32'd2);
      wait_strobe(1'b1, 30, n);
      check("clamp_interval", 32'(n), 32'd4);
      speed_up = 1; step(); speed_up = 0;
      wait_strobe(1'b1, 30, n);
      check("floor_interval_rest", 32'(n), 32'd3);
      check("floor_period_held", 32'(period), 32'd3);
      check("floor_level_held", 32'(level), 32'd2);

      // Pause for 25 clks, one clk into an interval of 4.
      step();
      pause = 1;
      strobes = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (game_tick || serve_tick) strobes++;
      end
      check("pause_no_strobes", 32'(strobes), 32'd0);
      check("pause_running_low", 32'(running), 32'd0);
      pause = 0;
      wait_strobe(1'b1, 30, n);
      check("pause_resume_remaining", 32'(n), 32'd3);
      check("pause_resume_running", 32'(running), 32'd1);

      // restart lands on the same edge as a RUN wrap and a speed_up.
      repeat (3) step();
      restart = 1; speed_up = 1;
      step();
      restart = 0; speed_up = 0;
      check("restart_game_suppr", 32'(game_tick), 32'd0);
      check("restart_serve_suppr", 32'(serve_tick), 32'd0);
      check("restart_period", 32'(period), 32'(START_PERIOD));
      check("restart_level", 32'(level), 32'd0);
      check("restart_running", 32'(running), 32'd0);
      wait_strobe(1'b0, 30, n);
      check("restart_serve1_gap", 32'(n), 32'd10);
      wait_strobe(1'b0, 30, n);
      check("restart_serve2_gap", 32'(n), 32'd10);
      check("restart_run_again", 32'(running), 32'd1);
      wait_strobe(1'b1, 30, n);
      check("restart_game_gap", 32'(n), 32'd10);
      check("restart_pend_cleared", 32'(period), 32'(START_PERIOD));

      // Asynchronous reset in the middle of a clock period while in RUN.
      step();
      #3;
      reset = 1; start = 1;
      #1;
      check("async_rst_running", 32'(running), 32'd0);
      check("async_rst_period", 32'(period), 32'(START_PERIOD));
      check("async_rst_strobes", 32'({game_tick, serve_tick}), 32'd0);
      repeat (2) step();
      reset = 0; start = 0;
      seen_serve = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (serve_tick || game_tick || running) seen_serve++;
      end
      check("start_ignored_in_reset", 32'(seen_serve), 32'd0);

      // Random stimulus compared against the reference model.
      for (int seg = 0; seg < 2; seg++) begin
         reset = 1; start = 0; restart = 0; speed_up = 0; pause = 0;
         step();
         reset = 0;
         model_reset();
         for (int c = 0; c < 2500; c++) begin
            start    = ($urandom_range(0, 19) == 0);
            restart  = ($urandom_range(0, 59) == 0);
            speed_up = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            model_step(start, restart, speed_up, pause);
            step();
            check($sformatf("rand%0d_%0d{game,serve,run,level,period}", seg, c),
                  32'({game_tick, serve_tick, running, level, period}),
                  32'({m_game, m_serve, (m_phase == P_RUN) && !m_paused,
                       LEVEL_W'(m_level), WIDTH'(m_period)}));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
